// File: rtl/branch_target_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_adder_pkg
// Brief    : Shared constants and types for the branch target adder.
// Revision : 1.0 - initial release
// ============================================================================
package branch_target_adder_pkg;

  // Data and address width of the core
  localparam int XLEN = 32;

  // RV32 major opcodes that produce a non-sequential target
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format selected by the opcode; IMM_NONE means "use +4"
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_B    = 3'd1,
    IMM_J    = 3'd2,
    IMM_I    = 3'd3,
    IMM_U    = 3'd4
  } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/branch_target_adder_imm_decode.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_adder_imm_decode
// Brief    : Selects the immediate format from the opcode and produces the
//            sign-extended immediate for the target adder.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_adder_imm_decode
  import branch_target_adder_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [31:0]       inst,
  output logic [XLEN_P-1:0] imm,
  output imm_fmt_e          fmt
);

  logic [6:0] opcode;
  assign opcode = inst[6:0];

  // Opcode to format, then assemble the matching sign-extended immediate
  always_comb begin
    fmt = IMM_NONE;
    imm = '0;
    unique case (opcode)
      OP_BRANCH: begin
        fmt = IMM_B;
        imm = {{(XLEN_P-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_JAL: begin
        fmt = IMM_J;
        imm = {{(XLEN_P-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        fmt = IMM_I;
        imm = {{(XLEN_P-12){inst[31]}}, inst[31:20]};
      end
      OP_AUIPC: begin
        fmt = IMM_U;
        imm = {{(XLEN_P-32){inst[31]}}, inst[31:12], 12'b0};
      end
      default: begin
        fmt = IMM_NONE;
        imm = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_adder
// Brief    : Combinational control-flow target generator for the branch FU,
//            with a one-cycle registered copy for debug/trace.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_adder
  import branch_target_adder_pkg::*;
#(
  parameter int XLEN_P     = XLEN,
  parameter int ALIGN_BITS = 2
) (
  input  logic              clock,
  input  logic              reset,          // asynchronous, active-low
  input  logic              in_valid,
  input  logic [XLEN_P-1:0] pc,
  input  logic [31:0]       inst,
  input  logic [XLEN_P-1:0] rs1_value,
  output logic [XLEN_P-1:0] result,
  output logic              misaligned,
  output logic [XLEN_P-1:0] result_q,
  output logic              result_valid_q
);

  localparam logic [XLEN_P-1:0] SEQ_STEP  = XLEN_P'(4);
  // JALR clears bit 0 of the sum
  localparam logic [XLEN_P-1:0] JALR_MASK = {{(XLEN_P-1){1'b1}}, 1'b0};

  logic [XLEN_P-1:0] imm;
  imm_fmt_e          fmt;
  logic [XLEN_P-1:0] base;
  logic [XLEN_P-1:0] offset;
  logic [XLEN_P-1:0] sum;

  branch_target_adder_imm_decode #(
    .XLEN_P (XLEN_P)
  ) u_imm_decode (
    .inst (inst),
    .imm  (imm),
    .fmt  (fmt)
  );

  // Base/offset select and a single wrap-around adder; carry-out is dropped
  always_comb begin
    base   = pc;
    offset = imm;
    if (fmt == IMM_I) begin
      base = rs1_value;
    end
    if (fmt == IMM_NONE) begin
      offset = SEQ_STEP;
    end
    sum    = base + offset;
    result = (fmt == IMM_I) ? (sum & JALR_MASK) : sum;
  end

  // Alignment flag is informational only; it never alters result
  assign misaligned = |result[ALIGN_BITS-1:0];

  // Trace copy: capture on valid issue, hold data otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_adder
// Brief    : Scoreboard bench for branch_target_adder: directed vectors plus
//            randomized instructions against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_adder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic [31:0] rs1_value = '0;
  logic [31:0] result;
  logic        misaligned;
  logic [31:0] result_q;
  logic        result_valid_q;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_q = '0;
  bit          mon_en = 1'b0;

  branch_target_adder dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .pc             (pc),
    .inst           (inst),
    .rs1_value      (rs1_value),
    .result         (result),
    .misaligned     (misaligned),
    .result_q       (result_q),
    .result_valid_q (result_valid_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: immediates as signed integers, targets as integer sums mod 2^32
  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] i,
                                             input logic [31:0] r);
    longint v;
    longint t;
    case (i[6:0])
      7'b1100011: begin
        v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0});
        if (i[31]) v = v - (longint'(1) << 13);
        t = longint'(p) + v;
      end
      7'b1101111: begin
        v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0});
        if (i[31]) v = v - (longint'(1) << 21);
        t = longint'(p) + v;
      end
      7'b1100111: begin
        v = longint'(i[31:20]);
        if (i[31]) v = v - (longint'(1) << 12);
        t = longint'(r) + v;
        t = t - (t & 1);
      end
      7'b0010111: begin
        v = longint'(i[31:12]) * 4096;
        t = longint'(p) + v;
      end
      default: t = longint'(p) + 4;
    endcase
    t = t & 64'h0000_0000_FFFF_FFFF;
    return t[31:0];
  endfunction

  // Drive one issue slot and check the zero-latency outputs
  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] r, input logic [31:0] exp_res, input string name);
    @(negedge clock);
    in_valid  = v;
    pc        = p;
    inst      = i;
    rs1_value = r;
    if (v && reset) exp_q.push_back(exp_res);
    #1;
    check({name, "_result"}, result, exp_res);
    check({name, "_misaligned"}, {31'b0, misaligned}, {31'b0, (exp_res % 4) != 0});
  endtask

  // Monitor: pop the expected trace value whenever the DUT shows a valid one
  always @(negedge clock) begin
    if (mon_en) begin
      if (result_valid_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_valid_q unexpected actual=1 expected=0");
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("result_q", result_q, e);
          last_q = e;
        end
      end else begin
        check("result_q_hold", result_q, last_q);
      end
    end
  end

  initial begin
    logic [6:0]  ops [5];
    logic [31:0] ri, rp, rr;
    ops[0] = 7'b1100011; ops[1] = 7'b1101111; ops[2] = 7'b1100111;
    ops[3] = 7'b0010111; ops[4] = 7'b0110011;

    // Reset state, and combinational path alive while in reset
    #1;
    check("reset_result_q", result_q, 32'h0);
    check("reset_valid_q", {31'b0, result_valid_q}, 32'h0);
    drive(1'b1, 32'h100, 32'h008000EF, 32'h0, 32'h108, "jal_in_reset");
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("reset_valid_lost", {31'b0, result_valid_q}, 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Directed vectors
    drive(1'b1, 32'h100,      32'h008000EF, 32'h0,     32'h108,      "jal");
    drive(1'b1, 32'h200,      32'hFE000EE3, 32'h0,     32'h1FC,      "beq_a");
    drive(1'b1, 32'h200,      32'hFE000EE3, 32'hDEAD,  32'h1FC,      "beq_b");
    drive(1'b1, 32'h40,       32'h00508067, 32'h1000,  32'h1004,     "jalr");
    drive(1'b1, 32'h10,       32'h12345017, 32'h0,     32'h12345010, "auipc");
    drive(1'b1, 32'hFFFFFFFC, 32'h00000033, 32'h0,     32'h0,        "add_wrap");
    drive(1'b1, 32'h0,        32'h00008067, 32'h1002,  32'h1002,     "jalr_mis");
    drive(1'b0, 32'h0,        32'h00000013, 32'h0,     32'h4,        "idle");
    drive(1'b1, 32'hFFFFFFFC, 32'h0080006F, 32'h0,     32'h4,        "jal_wrap");

    // Asynchronous reset while a valid trace entry is held
    @(posedge clock);
    #2;
    check("pre_reset_valid_q", {31'b0, result_valid_q}, 32'h1);
    reset = 1'b0;
    exp_q.delete();
    last_q = '0;
    #1;
    check("async_reset_result_q", result_q, 32'h0);
    check("async_reset_valid_q", {31'b0, result_valid_q}, 32'h0);
    drive(1'b1, 32'h300, 32'h008000EF, 32'h0, 32'h308, "jal_during_reset");
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_release_valid_q", {31'b0, result_valid_q}, 32'h0);
    check("post_release_result_q", result_q, 32'h0);

    // Randomized instructions against the reference model
    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) ri[6:0] = 7'($urandom);
      rp = $urandom;
      rr = $urandom;
      if ($urandom_range(0, 3) == 0) rp = rp | 32'hFFFFF000;
      drive(($urandom_range(0, 3) != 0), rp, ri, rr, ref_target(rp, ri, rr), "rand");
    end

    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'h0);
    check("final_valid_q", {31'b0, result_valid_q}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_target_adder.md
Name: branch_target_adder

Overview:
- Combinational address generator for the branch functional unit.
- Decodes the immediate from the issued instruction and forms the control-flow target: PC+imm for branches, JAL and AUIPC; (rs1+imm)&~1 for JALR; PC+4 otherwise.
- The combinational result feeds the branch FU's taken/target/correctness logic in the same cycle.
- Also provides a one-cycle registered copy with valid, for debug and trace.

Parameters:
- XLEN, 32, data and address width.
- ALIGN_BITS, 2, low address bits that must be zero for an aligned target (no compressed ISA).

Ports:
- clock  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- in_valid  in  1  issue packet valid this cycle.
- pc  in  XLEN  PC of the issued instruction.
- inst  in  32  raw RV32 instruction word.
- rs1_value  in  XLEN  rs1 operand, used by JALR only.
- result  out  XLEN  combinational target address.
- misaligned  out  1  combinational; result[ALIGN_BITS-1:0] != 0.
- result_q  out  XLEN  registered result.
- result_valid_q  out  1  registered in_valid.

Behaviour:
- Opcode is inst[6:0]. Immediates are RV32 formats, sign-extended to XLEN.
- BRANCH 1100011: result = pc + B-imm, where B-imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- JAL 1101111: result = pc + J-imm, where J-imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- JALR 1100111: result = (rs1_value + I-imm) with bit 0 forced to 0. I-imm = inst[31:20].
- AUIPC 0010111: result = pc + {inst[31:12], 12'b0}.
- Any other opcode: result = pc + 4.
- Funct3 is ignored. The branch condition is not evaluated here.
- All additions are modulo 2^XLEN; carry-out is discarded, so targets wrap, e.g. 0xFFFFFFFC + 8 = 0x00000004.
- result and misaligned are purely combinational, zero latency, and do not depend on in_valid.
- misaligned does not gate or alter result.
- Registered path:
  - On posedge clock with in_valid=1: result_q <= result; result_valid_q <= 1.
  - On posedge clock with in_valid=0: result_valid_q <= 0; result_q holds its previous value.
- Reset: while reset=0, asynchronously, result_q = 0 and result_valid_q = 0. The combinational outputs are unaffected by reset.
- Deassertion of reset takes effect at the next rising edge. An in_valid presented during reset is lost.
- No X-propagation: every opcode decodes to a defined result.

Decomposition:
- Shared package holds:
  - XLEN.
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC.
  - The immediate-format enum IMM_B/IMM_J/IMM_I/IMM_U/IMM_NONE.
- One natural sub-module: imm_decode (inst -> sign-extended imm plus format select). The adder, base mux and output register stay in the top module.

Test Plan:
- JAL x1,+8: inst=0x008000EF, pc=0x100 -> result=0x108, misaligned=0. Next edge with in_valid=1 -> result_q=0x108, result_valid_q=1.
- BEQ x0,x0,-4: inst=0xFE000EE3, pc=0x200 -> result=0x1FC, independent of rs1_value.
- JALR x0,5(x1): inst=0x00508067, rs1_value=0x1000, pc=0x40 -> result=0x1004 (bit 0 cleared), misaligned=0.
- AUIPC inst=0x12345017, pc=0x10 -> result=0x12345010. ADD opcode 0110011, pc=0xFFFFFFFC -> result=0x00000000 (wrap).
- JALR with rs1_value=0x1002, imm=0 -> result=0x1002, misaligned=1.
- Assert reset=0 mid-stream with result_valid_q=1 -> result_q=0 and result_valid_q=0 immediately, without waiting for a clock edge. in_valid=0 after release -> result_valid_q stays 0.
